// File: rtl/line_buffer_ctrl_pkg.sv
// Shared types and helpers for the line-buffer ring controller.
// Holds the default geometry, the read FSM state type and the ring index wrap.
package line_buffer_ctrl_pkg;

  localparam int LINE_WIDTH_DEF = 512;
  localparam int WIN_DEF        = 6;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_READ = 1'b1
  } rd_state_t;

  // Next index around a ring of n entries.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/line_buffer_ctrl_if.sv
// Pixel-in / window-out signal bundle of the line-buffer ring controller.
// Member names match the controller's port list, so i_/o_ are from the controller's view.
interface line_buffer_ctrl_if #(
  parameter int NUM_BUF = 7,
  parameter int IDX_W   = 3,
  parameter int COL_W   = 9
);
  import line_buffer_ctrl_pkg::*;

  // Handshakes: a pixel moves when i_pixel_valid & o_pixel_ready are both high on a
  // rising edge; a window strobe fires when the read FSM is reading and i_out_ready is high.
  logic               i_pixel_valid;
  logic               o_pixel_ready;
  logic [NUM_BUF-1:0] o_wr_valid;
  logic               i_out_ready;
  logic [NUM_BUF-1:0] o_rd_en;
  logic [IDX_W-1:0]   o_rd_base;
  logic               o_win_valid;
  logic [COL_W-1:0]   o_col;
  logic               o_line_done;

  modport master (
    output i_pixel_valid,
    output i_out_ready,
    input  o_pixel_ready,
    input  o_wr_valid,
    input  o_rd_en,
    input  o_rd_base,
    input  o_win_valid,
    input  o_col,
    input  o_line_done
  );

  modport slave (
    input  i_pixel_valid,
    input  i_out_ready,
    output o_pixel_ready,
    output o_wr_valid,
    output o_rd_en,
    output o_rd_base,
    output o_win_valid,
    output o_col,
    output o_line_done
  );

endinterface

// File: rtl/line_buffer_ctrl_ring_idx_counter.sv
// Mod-N ring index register with enable; used for the write buffer index and the
// oldest-row read base.
module ring_idx_counter
  import line_buffer_ctrl_pkg::*;
#(
  parameter int N = 7,
  parameter int W = 3
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  output logic [W-1:0] o_idx
);

  logic [W-1:0] r_idx;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_idx <= '0;
    end else if (i_en) begin
      r_idx <= W'(wrap_inc(32'(r_idx), N));
    end
  end

  assign o_idx = r_idx;

endmodule

// File: rtl/line_buffer_ctrl.sv
// Sequencing controller for a ring of NUM_BUF line buffers feeding a WIN x WIN window
// stage: steers writes, counts held lines, strobes the WIN read buffers together.
module line_buffer_ctrl
  import line_buffer_ctrl_pkg::*;
#(
  parameter int LINE_WIDTH = LINE_WIDTH_DEF,
  parameter int WIN        = WIN_DEF,
  parameter int NUM_BUF    = 7,
  parameter int IDX_W      = 3
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  line_buffer_ctrl_if.slave   bus,
  output rd_state_t           o_dbg_state,
  output logic [IDX_W:0]      o_dbg_lines_held
);

  localparam int COL_W = $clog2(LINE_WIDTH);
  localparam int CNT_W = IDX_W + 1;

  localparam logic [COL_W-1:0] COL_LAST      = COL_W'(LINE_WIDTH - 1);
  localparam logic [COL_W-1:0] COL_VALID_MAX = COL_W'(LINE_WIDTH - WIN);
  localparam logic [CNT_W-1:0] HELD_FULL     = CNT_W'(NUM_BUF);
  localparam logic [CNT_W-1:0] HELD_WIN      = CNT_W'(WIN);

  logic [COL_W-1:0]   r_wr_col;
  logic [COL_W-1:0]   r_rd_col;
  logic [CNT_W-1:0]   r_lines_held;
  rd_state_t          r_state;

  logic [CNT_W-1:0]   w_held_next;
  logic [IDX_W-1:0]   w_wr_idx;
  logic [IDX_W-1:0]   w_rd_base;
  logic               w_accept;
  logic               w_strobe;
  logic               w_wr_line_end;
  logic               w_rd_line_end;
  logic [NUM_BUF-1:0] w_rd_mask;

  // Ready is gated by reset so upstream sees 0 while reset is held, 1 on the first free cycle.
  assign bus.o_pixel_ready = i_rst_n & (r_lines_held < HELD_FULL);
  assign w_accept          = bus.i_pixel_valid & bus.o_pixel_ready;
  assign w_strobe          = i_rst_n & (r_state == RD_READ) & bus.i_out_ready;
  assign w_wr_line_end     = w_accept & (r_wr_col == COL_LAST);
  assign w_rd_line_end     = w_strobe & (r_rd_col == COL_LAST);

  always_comb begin
    w_held_next = r_lines_held;
    if (w_wr_line_end && !w_rd_line_end) begin
      w_held_next = r_lines_held + CNT_W'(1);
    end else if (w_rd_line_end && !w_wr_line_end) begin
      w_held_next = r_lines_held - CNT_W'(1);
    end
  end

  // Read set is the WIN buffers starting at the oldest row, wrapping around the ring.
  always_comb begin
    w_rd_mask = '0;
    for (int k = 0; k < NUM_BUF; k++) begin
      if (((k + NUM_BUF - int'(w_rd_base)) % NUM_BUF) < WIN) begin
        w_rd_mask[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_col     <= '0;
      r_rd_col     <= '0;
      r_lines_held <= '0;
      r_state      <= RD_IDLE;
    end else begin
      if (w_accept) begin
        r_wr_col <= w_wr_line_end ? '0 : r_wr_col + 1'b1;
      end
      if (w_strobe) begin
        r_rd_col <= w_rd_line_end ? '0 : r_rd_col + 1'b1;
      end
      r_lines_held <= w_held_next;
      // Decisions use the post-update count so a new line starts with no bubble cycle.
      case (r_state)
        RD_IDLE: if (w_held_next >= HELD_WIN) r_state <= RD_READ;
        RD_READ: if (w_rd_line_end && (w_held_next < HELD_WIN)) r_state <= RD_IDLE;
        default: r_state <= RD_IDLE;
      endcase
    end
  end

  ring_idx_counter #(
    .N (NUM_BUF),
    .W (IDX_W)
  ) u_wr_idx (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (w_wr_line_end),
    .o_idx   (w_wr_idx)
  );

  ring_idx_counter #(
    .N (NUM_BUF),
    .W (IDX_W)
  ) u_rd_base (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (w_rd_line_end),
    .o_idx   (w_rd_base)
  );

  assign bus.o_wr_valid  = w_accept ? (NUM_BUF'(1) << w_wr_idx) : '0;
  assign bus.o_rd_en     = w_strobe ? w_rd_mask : '0;
  assign bus.o_rd_base   = i_rst_n ? w_rd_base : '0;
  assign bus.o_col       = i_rst_n ? r_rd_col : '0;
  assign bus.o_win_valid = w_strobe & (r_rd_col <= COL_VALID_MAX);
  assign bus.o_line_done = w_rd_line_end;

  assign o_dbg_state      = r_state;
  assign o_dbg_lines_held = r_lines_held;

  a_held_max: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    r_lines_held <= HELD_FULL);

  a_no_underflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (w_rd_line_end && !w_wr_line_end) |-> (r_lines_held != '0));

  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (w_wr_line_end && !w_rd_line_end) |-> (r_lines_held < HELD_FULL));

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Scoreboard bench for line_buffer_ctrl: directed streams push timed expectations,
// a negedge monitor pops and compares whenever the controller presents an event.
module tb_line_buffer_ctrl;
  import line_buffer_ctrl_pkg::*;

  localparam int LW      = 512;
  localparam int WIN     = 6;
  localparam int NB      = 7;
  localparam int IW      = 3;
  localparam int CW      = 9;
  localparam int MAX_CYC = 20000;

  localparam int CK_RDY  = 0;
  localparam int CK_BASE = 1;
  localparam int CK_COL  = 2;
  localparam int CK_HELD = 3;

  localparam logic [6:0] WR_HOT  [0:6] = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h40};
  localparam logic [6:0] RD_MASK [0:6] = '{7'h3F, 7'h7E, 7'h7D, 7'h7B, 7'h77, 7'h6F, 7'h5F};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  logic tb_done = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  line_buffer_ctrl_if #(.NUM_BUF(NB), .IDX_W(IW), .COL_W(CW)) bus ();
  rd_state_t   dbg_state;
  logic [IW:0] dbg_held;

  line_buffer_ctrl #(
    .LINE_WIDTH (LW),
    .WIN        (WIN),
    .NUM_BUF    (NB),
    .IDX_W      (IW)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .bus              (bus.slave),
    .o_dbg_state      (dbg_state),
    .o_dbg_lines_held (dbg_held)
  );

  // ---------------- scoreboard queues ----------------
  logic [38:0] exp_wr_q[$];   // {cycle, one-hot write strobe}
  logic [52:0] exp_rd_q[$];   // {cycle, rd_en, rd_base, col, win_valid, line_done}
  logic [51:0] exp_ck_q[$];   // {cycle, selector, value}

  // ---------------- driver tasks ----------------
  task automatic drive(input logic rst, input logic v, input logic r);
    @(posedge clk);
    #1;
    rst_n             = rst;
    bus.i_pixel_valid = v;
    bus.i_out_ready   = r;
  endtask

  task automatic push_wr(input int b);
    exp_wr_q.push_back({32'(cyc), WR_HOT[b]});
  endtask

  task automatic push_rd(input int b, input int col);
    logic wv;
    logic ld;
    wv = (col <= LW - WIN);
    ld = (col == LW - 1);
    exp_rd_q.push_back({32'(cyc), RD_MASK[b], 3'(b), 9'(col), wv, ld});
  endtask

  task automatic push_ck(input int sel, input int val);
    exp_ck_q.push_back({32'(cyc), 4'(sel), 16'(val)});
  endtask

  initial begin
    rst_n             = 1'b0;
    bus.i_pixel_valid = 1'b0;
    bus.i_out_ready   = 1'b0;
    repeat (3) drive(1'b0, 1'b0, 1'b0);

    // First scenario, continued into back-to-back lines, reset at column 300 of read line 3.
    drive(1'b1, 1'b0, 1'b0);
    push_ck(CK_RDY, 1);
    push_ck(CK_HELD, 0);
    for (int n = 0; n <= 4396; n++) begin
      drive(1'b1, 1'b1, 1'b1);
      push_wr((n / LW) % NB);
      if (n >= 3072) push_rd((n - 3072) / LW, (n - 3072) % LW);
    end
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);

    // Fresh six-line stream must reproduce the first scenario.
    drive(1'b1, 1'b0, 1'b0);
    push_ck(CK_RDY, 1);
    push_ck(CK_HELD, 0);
    push_ck(CK_BASE, 0);
    for (int n = 0; n < 3584; n++) begin
      drive(1'b1, n < 3072, 1'b1);
      if (n < 3072) push_wr((n / LW) % NB);
      else          push_rd(0, n - 3072);
    end
    drive(1'b1, 1'b0, 1'b1);
    push_ck(CK_BASE, 1);
    push_ck(CK_HELD, 5);
    push_ck(CK_COL, 0);
    repeat (4) drive(1'b1, 1'b0, 1'b1);

    // Fill the ring with the consumer stalled.
    for (int n = 0; n < 1024; n++) begin
      drive(1'b1, 1'b1, 1'b0);
      push_wr((6 + n / LW) % NB);
    end
    for (int n = 0; n < 20; n++) begin
      drive(1'b1, 1'b1, 1'b0);
      push_ck(CK_RDY, 0);
      push_ck(CK_HELD, 7);
    end

    // Consumer ready on odd cycles only; upstream keeps offering pixels.
    for (int j = 0; j < 1024; j++) begin
      drive(1'b1, 1'b1, (j % 2) == 1);
      if ((j % 2) == 1) push_rd(1, (j - 1) / 2);
    end

    // Write-line end and read-line end land in the same cycle.
    for (int n = 0; n < 1024; n++) begin
      drive(1'b1, n < 522, 1'b1);
      if (n < 522) push_wr((1 + n / LW) % NB);
      push_rd((n < 512) ? 2 : 3, n % LW);
      if (n == 0) begin
        push_ck(CK_RDY, 1);
        push_ck(CK_HELD, 6);
      end
      if (n == 512) begin
        push_ck(CK_HELD, 6);
        push_ck(CK_BASE, 3);
      end
    end
    drive(1'b1, 1'b0, 1'b1);
    push_ck(CK_HELD, 5);
    push_ck(CK_BASE, 4);
    repeat (9) drive(1'b1, 1'b0, 1'b1);
    tb_done = 1'b1;
  end

  // ---------------- monitor / scoreboard ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  int          win_cnt = 0;
  logic        finished = 1'b0;
  logic [38:0] mon_wr;
  logic [52:0] mon_rd;
  logic [51:0] mon_ck;
  logic [31:0] ck_act;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic report();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  endtask

  always @(negedge clk) begin
    if (!finished) begin
      if (!rst_n) begin
        chk("reset_outputs", 64'({bus.o_pixel_ready, bus.o_wr_valid, bus.o_rd_en, bus.o_rd_base,
                                  bus.o_win_valid, bus.o_col, bus.o_line_done}), 64'h0);
        win_cnt = 0;
      end else begin
        if (bus.o_wr_valid != '0) begin
          if (exp_wr_q.size() == 0) begin
            chk("wr_unexpected", 64'({32'(cyc), bus.o_wr_valid}), 64'h0);
          end else begin
            mon_wr = exp_wr_q.pop_front();
            chk("wr_strobe", 64'({32'(cyc), bus.o_wr_valid}), 64'(mon_wr));
          end
        end
        if ((bus.o_rd_en != '0) || bus.o_win_valid || bus.o_line_done) begin
          if (bus.o_win_valid) win_cnt++;
          if (exp_rd_q.size() == 0) begin
            chk("rd_unexpected", 64'({32'(cyc), bus.o_rd_en, bus.o_rd_base, bus.o_col}), 64'h0);
          end else begin
            mon_rd = exp_rd_q.pop_front();
            chk("rd_strobe", 64'({32'(cyc), bus.o_rd_en, bus.o_rd_base, bus.o_col,
                                  bus.o_win_valid, bus.o_line_done}), 64'(mon_rd));
          end
          if (bus.o_line_done) begin
            chk("valid_windows_per_line", 64'(win_cnt), 64'd507);
            win_cnt = 0;
          end
        end
      end

      while ((exp_ck_q.size() > 0) && (int'(exp_ck_q[0][51:20]) <= cyc)) begin
        mon_ck = exp_ck_q.pop_front();
        case (int'(mon_ck[19:16]))
          CK_RDY:  ck_act = 32'(bus.o_pixel_ready);
          CK_BASE: ck_act = 32'(bus.o_rd_base);
          CK_COL:  ck_act = 32'(bus.o_col);
          default: ck_act = 32'(dbg_held);
        endcase
        chk("checkpoint", 64'({32'(cyc), 4'(mon_ck[19:16]), ck_act[15:0]}),
            64'({mon_ck[51:20], mon_ck[19:16], mon_ck[15:0]}));
      end

      if (tb_done) begin
        chk("wr_queue_left", 64'(exp_wr_q.size()), 64'h0);
        chk("rd_queue_left", 64'(exp_rd_q.size()), 64'h0);
        chk("ck_queue_left", 64'(exp_ck_q.size()), 64'h0);
        finished = 1'b1;
        report();
      end else if (cyc > MAX_CYC) begin
        chk("timeout", 64'(cyc), 64'(MAX_CYC));
        finished = 1'b1;
        report();
      end
    end
  end

endmodule
